// File: rtl/multicycle_control_pkg.sv
// Shared encodings for the multicycle controller and its datapath:
// FSM state codes, opcode values and mux/ALU select codes.
package multicycle_control_pkg;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_RWB    = 4'd7,
    S_BRANCH = 4'd8,
    S_JUMP   = 4'd9,
    S_ADDIEX = 4'd10,
    S_ADDIWB = 4'd11,
    S_TRAP   = 4'd12
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  localparam logic [1:0] SRCB_REG     = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SHL = 2'b11;

endpackage

// File: rtl/multicycle_control.sv
// Multicycle CPU control FSM: sequences fetch/decode/execute/memory/writeback,
// drives datapath strobes and counts retired instructions.
//
// state  | meaning
// FETCH  | read instruction, PC+4; waits on mem_ready
// DECODE | register read, branch target compute; dispatch on opcode
// MEMADR | effective address for lw/sw
// MEMRD  | data read; waits on mem_ready
// MEMWB  | load writeback
// MEMWR  | data write; waits on mem_ready
// EXEC   | R-type ALU operation
// RWB    | R-type writeback
// BRANCH | beq compare and conditional PC update
// JUMP   | unconditional PC update
// ADDIEX | addi ALU operation
// ADDIWB | addi writeback
// TRAP   | illegal opcode; absorbing until reset
module multicycle_control
  import multicycle_control_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       opcode,
  input  logic             mem_ready,
  output logic             PCWrite,
  output logic             PCWriteCond,
  output logic             IorD,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             MemtoReg,
  output logic             IRWrite,
  output logic             RegWrite,
  output logic             RegDst,
  output logic             ALUSrcA,
  output logic [1:0]       PCSource,
  output logic [1:0]       ALUOp,
  output logic [1:0]       ALUSrcB,
  output logic             trap,
  output logic [3:0]       state,
  output logic [CNT_W-1:0] instr_count
);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_FETCH;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:  if (mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_RTYPE:     state_d = S_EXEC;
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_BEQ:       state_d = S_BRANCH;
          OP_J:         state_d = S_JUMP;
          OP_ADDI:      state_d = S_ADDIEX;
          default:      state_d = S_TRAP;
        endcase
      end
      S_MEMADR: state_d = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:  if (mem_ready) state_d = S_MEMWB;
      S_MEMWB:  state_d = S_FETCH;
      S_MEMWR:  if (mem_ready) state_d = S_FETCH;
      S_EXEC:   state_d = S_RWB;
      S_RWB:    state_d = S_FETCH;
      S_BRANCH: state_d = S_FETCH;
      S_JUMP:   state_d = S_FETCH;
      S_ADDIEX: state_d = S_ADDIWB;
      S_ADDIWB: state_d = S_FETCH;
      S_TRAP:   state_d = S_TRAP;
      default:  state_d = S_TRAP;
    endcase
  end

  // Only the last state of an instruction ever re-enters FETCH, so that edge is retirement.
  always_comb begin
    cnt_d = cnt_q;
    if (state_d == S_FETCH && state_q != S_FETCH) cnt_d = cnt_q + CNT_W'(1);
  end

  always_comb begin
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    MemtoReg    = 1'b0;
    IRWrite     = 1'b0;
    RegWrite    = 1'b0;
    RegDst      = 1'b0;
    ALUSrcA     = 1'b0;
    PCSource    = PCSRC_ALU;
    ALUOp       = ALUOP_ADD;
    ALUSrcB     = SRCB_REG;
    case (state_q)
      S_FETCH: begin
        MemRead = 1'b1;
        ALUSrcB = SRCB_FOUR;
        // reset gates the only input-dependent strobes so nothing fires while held
        IRWrite = mem_ready & reset;
        PCWrite = mem_ready & reset;
      end
      S_DECODE: ALUSrcB = SRCB_IMM_SHL;
      S_MEMADR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = SRCB_IMM;
      end
      S_MEMRD: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
      end
      S_MEMWB: begin
        MemtoReg = 1'b1;
        RegWrite = 1'b1;
      end
      S_MEMWR: begin
        MemWrite = 1'b1;
        IorD     = 1'b1;
      end
      S_EXEC: begin
        ALUSrcA = 1'b1;
        ALUOp   = ALUOP_FUNCT;
      end
      S_RWB: begin
        RegDst   = 1'b1;
        RegWrite = 1'b1;
      end
      S_BRANCH: begin
        ALUSrcA     = 1'b1;
        ALUOp       = ALUOP_SUB;
        PCWriteCond = 1'b1;
        PCSource    = PCSRC_ALUOUT;
      end
      S_JUMP: begin
        PCWrite  = 1'b1;
        PCSource = PCSRC_JUMP;
      end
      S_ADDIEX: begin
        ALUSrcA = 1'b1;
        ALUSrcB = SRCB_IMM;
      end
      S_ADDIWB: RegWrite = 1'b1;
      default: ;
    endcase
  end

  assign trap        = (state_q == S_TRAP);
  assign state       = state_q;
  assign instr_count = cnt_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control: instruction-level model predicts the
// per-cycle state, control word and retired count; a monitor pops and compares.
module tb_multicycle_control;
  import multicycle_control_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] opcode;
  logic       mem_ready;
  logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg;
  logic       IRWrite, RegWrite, RegDst, ALUSrcA, trap;
  logic [1:0] PCSource, ALUOp, ALUSrcB;
  logic [3:0] state;
  logic [3:0] instr_count;

  multicycle_control #(.CNT_W(4)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD), .MemRead(MemRead),
    .MemWrite(MemWrite), .MemtoReg(MemtoReg), .IRWrite(IRWrite), .RegWrite(RegWrite),
    .RegDst(RegDst), .ALUSrcA(ALUSrcA), .PCSource(PCSource), .ALUOp(ALUOp),
    .ALUSrcB(ALUSrcB), .trap(trap), .state(state), .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]  st;
    logic [16:0] ctl;
    logic [3:0]  cnt;
  } exp_t;

  exp_t       sb[$];
  int         checks = 0;
  int         errors = 0;
  logic [3:0] cnt_m  = 4'd0;

  // Control word per state taken straight from the state/strobe table.
  function automatic logic [16:0] ctl_of(input state_t s, input logic mr);
    logic pcw, pcwc, iord, mrd, mwr, m2r, irw, rw, rdst, srca, trp;
    logic [1:0] pcs, aop, srcb;
    {pcw, pcwc, iord, mrd, mwr, m2r, irw, rw, rdst, srca, trp} = '0;
    {pcs, aop, srcb} = '0;
    case (s)
      S_FETCH:  begin mrd = 1; srcb = 2'b01; irw = mr; pcw = mr; end
      S_DECODE: srcb = 2'b11;
      S_MEMADR: begin srca = 1; srcb = 2'b10; end
      S_MEMRD:  begin mrd = 1; iord = 1; end
      S_MEMWB:  begin m2r = 1; rw = 1; end
      S_MEMWR:  begin mwr = 1; iord = 1; end
      S_EXEC:   begin srca = 1; aop = 2'b10; end
      S_RWB:    begin rdst = 1; rw = 1; end
      S_BRANCH: begin srca = 1; aop = 2'b01; pcwc = 1; pcs = 2'b01; end
      S_JUMP:   begin pcw = 1; pcs = 2'b10; end
      S_ADDIEX: begin srca = 1; srcb = 2'b10; end
      S_ADDIWB: rw = 1;
      S_TRAP:   trp = 1;
      default: ;
    endcase
    return {pcw, pcwc, iord, mrd, mwr, m2r, irw, rw, rdst, srca, pcs, aop, srcb, trp};
  endfunction

  function automatic logic [5:0] rnd6();
    return 6'($urandom);
  endfunction

  function automatic logic rbit();
    return 1'($urandom);
  endfunction

  task automatic chk(input string nm, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", nm, got, exp);
    end
  endtask

  // One clock of stimulus: drive inputs after the edge and predict this cycle.
  task automatic cyc(input state_t s, input logic mr, input logic [5:0] opc);
    @(posedge clk);
    #1;
    mem_ready = mr;
    opcode    = opc;
    sb.push_back('{st: s, ctl: ctl_of(s, mr), cnt: cnt_m});
  endtask

  // kind: 0 R-type, 1 lw, 2 sw, 3 beq, 4 j, 5 addi; fw/mw are stall counts.
  task automatic do_instr(input int kind, input int fw, input int mw);
    logic [5:0] opc;
    repeat (fw) cyc(S_FETCH, 1'b0, rnd6());
    cyc(S_FETCH, 1'b1, rnd6());
    case (kind)
      0: opc = 6'b000000;
      1: opc = 6'b100011;
      2: opc = 6'b101011;
      3: opc = 6'b000100;
      4: opc = 6'b000010;
      default: opc = 6'b001000;
    endcase
    cyc(S_DECODE, rbit(), opc);
    case (kind)
      0: begin cyc(S_EXEC, rbit(), rnd6()); cyc(S_RWB, rbit(), rnd6()); end
      1: begin
        cyc(S_MEMADR, rbit(), opc);
        repeat (mw) cyc(S_MEMRD, 1'b0, rnd6());
        cyc(S_MEMRD, 1'b1, rnd6());
        cyc(S_MEMWB, rbit(), rnd6());
      end
      2: begin
        cyc(S_MEMADR, rbit(), opc);
        repeat (mw) cyc(S_MEMWR, 1'b0, rnd6());
        cyc(S_MEMWR, 1'b1, rnd6());
      end
      3: cyc(S_BRANCH, rbit(), rnd6());
      4: cyc(S_JUMP, rbit(), rnd6());
      default: begin cyc(S_ADDIEX, rbit(), rnd6()); cyc(S_ADDIWB, rbit(), rnd6()); end
    endcase
    cnt_m = cnt_m + 4'd1;
  endtask

  task automatic release_reset();
    @(posedge clk);
    #1;
    mem_ready = 1'b0;
    reset     = 1'b1;
  endtask

  always @(negedge clk) begin
    if (reset) begin
      checks++;
      if ((MemRead && MemWrite) || (RegWrite && PCWrite)) begin
        errors++;
        $display("FAIL excl rd=%0b wr=%0b rw=%0b pcw=%0b", MemRead, MemWrite, RegWrite, PCWrite);
      end
      if (sb.size() > 0) begin
        exp_t e;
        logic [16:0] act;
        e   = sb.pop_front();
        act = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite, RegWrite,
               RegDst, ALUSrcA, PCSource, ALUOp, ALUSrcB, trap};
        checks++;
        if (state !== e.st || act !== e.ctl || instr_count !== e.cnt) begin
          errors++;
          $display("FAIL sb t=%0t state got=%0d exp=%0d ctl got=%b exp=%b cnt got=%0d exp=%0d",
                   $time, state, e.st, act, e.ctl, instr_count, e.cnt);
        end
      end
    end
  end

  initial begin
    reset     = 1'b0;
    mem_ready = 1'b1;
    opcode    = 6'b100011;
    #12;
    chk("rst_state", int'(state), 0);
    chk("rst_cnt", int'(instr_count), 0);
    chk("rst_irwrite", int'(IRWrite), 0);
    chk("rst_pcwrite", int'(PCWrite), 0);
    chk("rst_memread", int'(MemRead), 1);
    chk("rst_trap", int'(trap), 0);
    release_reset();

    do_instr(1, 0, 0);
    do_instr(2, 0, 3);
    do_instr(0, 0, 0);
    do_instr(3, 0, 0);
    do_instr(4, 0, 0);

    for (int i = 0; i < 60; i++)
      do_instr(int'($urandom_range(0, 5)), int'($urandom_range(0, 2)), int'($urandom_range(0, 3)));

    cyc(S_FETCH, 1'b1, rnd6());
    cyc(S_DECODE, 1'b1, 6'b100011);
    cyc(S_MEMADR, 1'b1, 6'b100011);
    cyc(S_MEMRD, 1'b0, rnd6());
    @(negedge clk);
    #2;
    reset     = 1'b0;
    mem_ready = 1'b1;
    #1;
    chk("abort_state", int'(state), 0);
    chk("abort_cnt", int'(instr_count), 0);
    chk("abort_regwrite", int'(RegWrite), 0);
    chk("abort_irwrite", int'(IRWrite), 0);
    cnt_m = 4'd0;
    release_reset();

    repeat (17) do_instr(5, 0, 0);
    cyc(S_FETCH, 1'b0, rnd6());
    @(negedge clk);
    #1;
    chk("wrap_cnt", int'(instr_count), 1);

    cyc(S_FETCH, 1'b1, rnd6());
    cyc(S_DECODE, rbit(), 6'b111111);
    repeat (10) cyc(S_TRAP, 1'b1, rnd6());
    @(negedge clk);
    #1;
    chk("trap_flag", int'(trap), 1);
    chk("trap_cnt", int'(instr_count), 1);
    chk("sb_drained", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
